// File: rtl/mem_arbiter4_if.sv
// Shared HACK data-memory port bundle between four requesters and the arbiter.
// The arbiter sits on the slave modport; the requester/memory side uses master.
interface mem_arbiter4_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 16
);
  logic [3:0]      req;
  logic [3:0]      last;
  logic [3:0]      we_in;
  logic [4*AW-1:0] addr_in;
  logic [4*DW-1:0] wdata_in;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   rdata;
  logic [3:0]      rvalid;

  modport slave (
    input  req, last, we_in, addr_in, wdata_in, mem_rdata,
    output gnt, sel, mem_addr, mem_wdata, mem_we, rdata, rvalid
  );

  modport master (
    output req, last, we_in, addr_in, wdata_in, mem_rdata,
    input  gnt, sel, mem_addr, mem_wdata, mem_we, rdata, rvalid
  );
endinterface

// File: rtl/mem_arbiter4.sv
// Four-way round-robin arbiter for the HACK data-memory port with a bounded hold time.
// Define ARB_PRIO0_EN to give requester 0 (CPU) absolute priority and exempt it from MAX_HOLD.
module mem_arbiter4 #(
  parameter int unsigned AW       = 15,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic            clk,
  input logic            reset,
  mem_arbiter4_if.slave  bus
);

`ifdef ARB_PRIO0_EN
  localparam bit Prio0En = 1'b1;
`else
  localparam bit Prio0En = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rvalid_q, rvalid_d;

  logic       busy, beat, at_cap, rel;
  logic [2:0] idle_pick, hand_pick;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}: scan base+1, base+2, base+3 and, if incl_base, base itself.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base,
                                      input logic incl_base);
    logic       found;
    logic [1:0] idx, cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!found && r[cand] && (i < 4 || incl_base)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (Prio0En && r[0] && (incl_base || base != 2'd0)) begin
      found = 1'b1;
      idx   = 2'd0;
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;

    busy      = (state_q == StBusy);
    beat      = busy && bus.req[sel_q];
    at_cap    = (cnt_q == 4'(MAX_HOLD - 1)) && !(Prio0En && sel_q == 2'd0);
    rel       = busy && (!bus.req[sel_q] || (beat && (bus.last[sel_q] || at_cap)));
    idle_pick = pick(bus.req, ptr_q, 1'b1);
    hand_pick = pick(bus.req, sel_q, 1'b0);

    // Read index captured at beat time so a handoff cannot misroute the return.
    if (beat && !bus.we_in[sel_q]) rvalid_d = onehot(sel_q);
    if (beat) cnt_d = cnt_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (idle_pick[2]) begin
          sel_d   = idle_pick[1:0];
          gnt_d   = onehot(idle_pick[1:0]);
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (rel) begin
          if (!(Prio0En && sel_q == 2'd0)) ptr_d = sel_q;
          cnt_d = '0;
          if (hand_pick[2]) begin
            sel_d = hand_pick[1:0];
            gnt_d = onehot(hand_pick[1:0]);
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= 2'd0;
      gnt_q    <= 4'd0;
      ptr_q    <= 2'd3;
      cnt_q    <= 4'd0;
      rvalid_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_addr  = busy ? bus.addr_in[sel_q*AW +: AW] : '0;
  assign bus.mem_wdata = busy ? bus.wdata_in[sel_q*DW +: DW] : '0;
  assign bus.mem_we    = beat && bus.we_in[sel_q];

endmodule

// File: tb/tb_mem_arbiter4.sv
// Directed bench for mem_arbiter4: grants, rotation, handoff, read routing and reset.
module tb_mem_arbiter4;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic [3:0] exp_q[$];

  mem_arbiter4_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter4 #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pops the next scoreboard entry and compares it against an observed 4-bit value.
  task automatic chk_pop(input string tag, input logic [3:0] obs);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, {28'd0, obs}, {28'd0, exp});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.last      = '0;
    bus.we_in     = '0;
    bus.addr_in   = '0;
    bus.wdata_in  = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    exp_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    clear_inputs();

    // Reset state and first grant with a read beat
    do_reset();
    chk("rst_gnt", {28'd0, bus.gnt}, 32'h0);
    chk("rst_sel", {30'd0, bus.sel}, 32'h0);
    chk("rst_rvalid", {28'd0, bus.rvalid}, 32'h0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'h0);
    bus.req = 4'b0001;
    bus.addr_in[0*AW +: AW] = 15'h0010;
    #1;
    chk("idle_mem_addr", {17'd0, bus.mem_addr}, 32'h0);
    step();
    chk("first_gnt", {28'd0, bus.gnt}, 32'h1);
    chk("first_sel", {30'd0, bus.sel}, 32'h0);
    chk("first_addr", {17'd0, bus.mem_addr}, 32'h0010);
    chk("first_we", {31'd0, bus.mem_we}, 32'h0);
    exp_q.push_back(4'b0001);
    bus.mem_rdata = 16'h1234;
    step();
    chk_pop("first_rvalid", bus.rvalid);
    chk("first_rdata", {16'd0, bus.rdata}, 32'h1234);

    // Full rotation: every requester gets exactly four beats, no idle cycles
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) exp_q.push_back(4'b0001 << ((k / 4) % 4));
    for (int k = 0; k < 20; k++) begin
      step();
      chk_pop($sformatf("rot_gnt_%0d", k), bus.gnt);
    end

    // Write beat with last from requester 2, search wraps 3 -> 0 -> 1
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("w2_gnt", {28'd0, bus.gnt}, 32'h4);
    bus.req   = 4'b0110;
    bus.last  = 4'b0100;
    bus.we_in = 4'b0100;
    bus.addr_in[2*AW +: AW]  = 15'h4000;
    bus.wdata_in[2*DW +: DW] = 16'hBEEF;
    #1;
    chk("w2_mem_we", {31'd0, bus.mem_we}, 32'h1);
    chk("w2_mem_addr", {17'd0, bus.mem_addr}, 32'h4000);
    chk("w2_mem_wdata", {16'd0, bus.mem_wdata}, 32'hBEEF);
    step();
    chk("w2_handoff_gnt", {28'd0, bus.gnt}, 32'h2);
    chk("w2_no_rvalid", {28'd0, bus.rvalid}, 32'h0);

    // Read on release cycle of 1 with handoff to 3 returns to 1
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("r1_gnt", {28'd0, bus.gnt}, 32'h2);
    bus.req  = 4'b1010;
    bus.last = 4'b0010;
    exp_q.push_back(4'b0010);
    step();
    chk("r1_handoff_gnt", {28'd0, bus.gnt}, 32'h8);
    chk_pop("r1_rvalid", bus.rvalid);

    // Reset during requester 3's grant abandons the pending read
    do_reset();
    bus.req = 4'b1000;
    step();
    chk("rst3_gnt", {28'd0, bus.gnt}, 32'h8);
    reset = 1'b1;
    step();
    chk("rst3_gnt_clr", {28'd0, bus.gnt}, 32'h0);
    chk("rst3_rvalid_clr", {28'd0, bus.rvalid}, 32'h0);
    reset = 1'b0;
    step();
    chk("rst3_regrant", {28'd0, bus.gnt}, 32'h8);

    // Requester 0 joins while 1 holds the port
    do_reset();
    bus.req = 4'b0110;
    step();
    chk("p0_first_gnt", {28'd0, bus.gnt}, 32'h2);
    bus.req = 4'b0111;
`ifdef ARB_PRIO0_EN
    for (int k = 0; k < 3; k++) exp_q.push_back(4'b0010);
    for (int k = 0; k < 9; k++) exp_q.push_back(4'b0001);
`else
    for (int k = 0; k < 3; k++) exp_q.push_back(4'b0010);
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b0100);
    for (int k = 0; k < 4; k++) exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
`endif
    for (int k = 0; k < 12; k++) begin
      step();
      chk_pop($sformatf("p0_gnt_%0d", k), bus.gnt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter4.md
# mem_arbiter4

Four-requester round-robin arbiter that shares the single HACK data-memory port (15-bit address, 16-bit word) between up to four masters: the CPU, a screen refresher, a keyboard scanner and a DMA loader. It registers a one-hot grant plus a 2-bit encoded select. The select drives the existing 1-to-4 demultiplexer on the read-return path. The arbiter muxes the granted requester's address, data and write-enable onto the memory port. It enforces a bounded hold time so that no requester can starve the others.

## Interface
- `AW`, 15, address width
- `DW`, 16, data word width
- `MAX_HOLD`, 4, maximum beats per grant before forced rotation (1..15)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  4  request per requester; must stay high while it wants beats
- `last`  in  4  marks requester's final beat; sampled only with its `req`
- `we_in`  in  4  per-requester write enable
- `addr_in`  in  4*AW  requester i address at bits [i*AW +: AW]
- `wdata_in`  in  4*DW  requester i write data at bits [i*DW +: DW]
- `gnt`  out  4  registered one-hot grant
- `sel`  out  2  registered encoded index of `gnt` (demux select)
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  DW  memory read data, valid one cycle after read beat
- `rdata`  out  DW  `mem_rdata` passthrough to all requesters
- `rvalid`  out  4  registered one-hot read-data-valid

## Operation
- States:
  - IDLE: `gnt`=0.
  - BUSY: `gnt`=onehot(`sel`).
- Rotation pointer `ptr` (2 bit) holds index of last granted requester.
- IDLE: if `req`≠0, choose first set bit searching `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4). Load `sel`/`gnt`, clear `cnt`, go BUSY. If `req`=0, stay in IDLE.
- BUSY beat: cycle where `req[sel]`=1.
  - `mem_addr`/`mem_wdata` = slice `sel` of inputs.
  - `mem_we` = `we_in[sel]`.
  - `cnt` increments (4-bit).
- BUSY with `req[sel]`=0: no beat. `mem_we`=0 and grant releases this cycle.
- Release condition, in BUSY, evaluated each cycle: any of the following ends the grant:
  - `req[sel]`=0
  - beat with `last[sel]`=1
  - beat with `cnt`=MAX_HOLD-1
- On release:
  - `ptr`←`sel`.
  - Search the other three requesters in rotation order, starting at `sel+1`; the current requester is excluded.
  - If one is found: direct handoff. Load new `sel`/`gnt`, `cnt`←0, stay in BUSY, with no idle cycle.
  - If none is found: go to IDLE. The current requester may re-win from IDLE on a later cycle.
- Outside BUSY: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- Read return:
  - `rvalid` next cycle = onehot(`sel`) if the beat had `we_in[sel]`=0, else 0.
  - The index is captured at beat time, so a handoff in between does not misroute data.
- Write and read beats may freely interleave within one grant.
- Reset mid-grant: the in-flight beat is abandoned and `rvalid` is cleared. The memory write of the current cycle still occurs, because it is combinational in that cycle.

## Timing
- Reset values: state IDLE, `gnt`=0, `sel`=0, `ptr`=3 (requester 0 wins first), `cnt`=0, `rvalid`=0, `mem_we`=0.
- Grant latency: `req` rising in IDLE gives `gnt` in the next cycle, and the first beat happens in that cycle.
- Handoff: last beat of A in cycle N; B's first beat in cycle N+1.
- Read latency: `rvalid`/`rdata` exactly one cycle after the read beat.
- Hold bound: at most MAX_HOLD consecutive beats per grant. Worst-case wait for any requester is 3×MAX_HOLD + 1 cycles.
- Output paths:
  - `mem_*` are combinational from registered `sel` plus the inputs.
  - `gnt`, `sel` and `rvalid` are registered.

## Configuration
- `ARB_PRIO0_EN` defined:
  - Requester 0 (CPU) wins every selection, in IDLE and at handoff, whenever `req[0]`=1.
  - Requester 0 is exempt from MAX_HOLD.
  - `ptr` updates only on grants to requesters 1–3, so round-robin applies among 1–3.
- `ARB_PRIO0_EN` undefined: pure round-robin over all four; MAX_HOLD applies to everyone.

## Test plan
- Reset, then `req`=0001 → `gnt`=0001 and `sel`=0 in cycle 1. A read beat at address 0x0010 gives `rvalid`=0001 one cycle later, with `rdata`=`mem_rdata`.
- `req`=1111 held, `last`=0, MAX_HOLD=4 → grant sequence 0,1,2,3,0, each 4 beats, handoffs with zero idle cycles.
- Requester 2 issues write beat (addr 0x4000, data 0xBEEF) with `last`=1 while `req`=0110 → `mem_we`=1 with those values that cycle, then `gnt`=0010 next cycle, search wrapping from 3 to 1.
- Read beat from requester 1 on its release cycle with handoff to 3 → `rvalid`=0010 (not 1000) the next cycle.
- Assert `reset` during requester 3's grant with `req`=1000 held → `gnt`=0 and `rvalid`=0 the next cycle. Regrant to 3 one cycle after `reset` deasserts.
- With `ARB_PRIO0_EN`: `req`=0110 active on 1, then `req[0]` rises → 0 granted at the next release and holds for more than 4 beats. Without the macro, 0 is limited to 4 beats.
